cacheline_burst_adaptor: RTL and testbench

//  Converts one 256-bit cache-line transaction from the eviction write buffer into a
//  4-beat x 64-bit burst on the physical-memory bus, and the reverse for line fills.

---
 rtl/cacheline_burst_adaptor_pkg.sv | 17 +
 rtl/cacheline_burst_adaptor.sv | 114 +++++++++++
 tb/tb_cacheline_burst_adaptor.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared constants and FSM encoding for the cache-line <-> pmem burst adaptor.
// Ports: none (package). Default widths: 256-bit line, 64-bit beat.
// States are plain localparam constants so older code can compare raw 2-bit values.
package cacheline_burst_adaptor_pkg;

  localparam int CL_LINE_W  = 256;
  localparam int CL_BURST_W = 64;
  localparam int CL_ADDR_W  = 32;

  typedef logic [1:0] adaptor_state_t;

  localparam adaptor_state_t ST_IDLE = 2'd0;
  localparam adaptor_state_t ST_RD   = 2'd1;
  localparam adaptor_state_t ST_WR   = 2'd2;
  localparam adaptor_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// Purpose: turns one cache-line read/write into a BEATS-beat pmem burst (and reassembles reads).
// Latency: 1 accept cycle + BEATS burst_resp cycles + 1 DONE cycle (6 cycles zero-wait, request cycle = 1).
// Backpressure: pmem stalls by withholding burst_resp; one transaction in flight, requests ignored while busy.
// Ports: clk/rst_n; line_read/line_write/line_addr/line_wdata in, line_rdata/line_resp out (requester side);
//        burst_rdata/burst_resp in, burst_read/burst_write/burst_addr/burst_wdata out (pmem side).
module cacheline_burst_adaptor
  import cacheline_burst_adaptor_pkg::*;
#(
  parameter int LINE_W  = CL_LINE_W,   // must be an exact multiple of BURST_W
  parameter int BURST_W = CL_BURST_W,
  parameter int ADDR_W  = CL_ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               line_read,
  input  logic               line_write,
  input  logic [ADDR_W-1:0]  line_addr,
  input  logic [LINE_W-1:0]  line_wdata,
  output logic [LINE_W-1:0]  line_rdata,
  output logic               line_resp,
  input  logic [BURST_W-1:0] burst_rdata,
  input  logic               burst_resp,
  output logic               burst_read,
  output logic               burst_write,
  output logic [ADDR_W-1:0]  burst_addr,
  output logic [BURST_W-1:0] burst_wdata
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  adaptor_state_t    state;
  logic [CNT_W-1:0]  cnt;
  logic [LINE_W-1:0] line_buf;
  logic [LINE_W-1:0] rd_line;
  logic              last_beat;

  assign last_beat = (cnt == LAST_BEAT);

  // Buffer with the current beat merged in, so the final beat lands in
  // line_rdata on the same edge that moves the FSM to DONE.
  always_comb begin
    rd_line = line_buf;
    rd_line[cnt*BURST_W +: BURST_W] = burst_rdata;
  end

  // Write beats are indexed straight out of the latched line; no shifting.
  assign burst_wdata = (state == ST_WR) ? line_buf[cnt*BURST_W +: BURST_W] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      line_buf    <= '0;
      line_rdata  <= '0;
      line_resp   <= 1'b0;
      burst_read  <= 1'b0;
      burst_write <= 1'b0;
      burst_addr  <= '0;
    end else begin
      line_resp <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (line_read || line_write) begin
            burst_addr <= {line_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            cnt        <= '0;
            // Read wins when both requests are raised together.
            if (line_read) begin
              state      <= ST_RD;
              burst_read <= 1'b1;
            end else begin
              state       <= ST_WR;
              burst_write <= 1'b1;
              line_buf    <= line_wdata;
            end
          end
        end
        ST_RD: begin
          if (burst_resp) begin
            line_buf <= rd_line;
            if (last_beat) begin
              state      <= ST_DONE;
              cnt        <= '0;
              burst_read <= 1'b0;
              line_resp  <= 1'b1;
              line_rdata <= rd_line;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_WR: begin
          if (burst_resp) begin
            if (last_beat) begin
              state       <= ST_DONE;
              cnt         <= '0;
              burst_write <= 1'b0;
              line_resp   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          // DONE: line_resp is high this cycle; requests are not looked at until IDLE.
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor: reset abort, zero-wait and stalled reads,
// write beat ordering, read/write priority and back-to-back transactions.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_cacheline_burst_adaptor;

  logic         clk;
  logic         rst_n;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_addr;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [63:0]  burst_rdata;
  logic         burst_resp;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_addr;
  logic [63:0]  burst_wdata;

  int n_assert;
  int n_fail;
  int resp_seen;

  cacheline_burst_adaptor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .line_read   (line_read),
    .line_write  (line_write),
    .line_addr   (line_addr),
    .line_wdata  (line_wdata),
    .line_rdata  (line_rdata),
    .line_resp   (line_resp),
    .burst_rdata (burst_rdata),
    .burst_resp  (burst_resp),
    .burst_read  (burst_read),
    .burst_write (burst_write),
    .burst_addr  (burst_addr),
    .burst_wdata (burst_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; counts every cycle in which line_resp is seen high.
  task automatic step();
    @(posedge clk);
    #1;
    if (line_resp === 1'b1) resp_seen++;
  endtask

  // Zero-wait read: request cycle, accept edge, then one beat per edge.
  task automatic zw_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [255:0] line, input logic both);
    int r0;
    r0 = resp_seen;
    line_read   = 1'b1;
    line_write  = both;
    line_addr   = addr;
    line_wdata  = {4{64'hBAD0_BAD0_BAD0_BAD0}};
    burst_resp  = 1'b1;
    burst_rdata = line[63:0];
    step();
    chk({tag, "_rd_strobe"}, burst_read, 1'b1);
    chk({tag, "_wr_strobe"}, burst_write, 1'b0);
    chk({tag, "_addr"}, burst_addr, exp_addr);
    line_read  = 1'b0;
    line_write = 1'b0;
    line_addr  = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      burst_rdata = line[i*64 +: 64];
      step();
      chk({tag, "_wr_idle"}, burst_write, 1'b0);
      if (i < 3) begin
        chk({tag, "_resp_early"}, line_resp, 1'b0);
        chk({tag, "_rd_held"}, burst_read, 1'b1);
      end else begin
        chk({tag, "_resp_cycle6"}, line_resp, 1'b1);
        chk({tag, "_rd_drop"}, burst_read, 1'b0);
        chk({tag, "_rdata"}, line_rdata, line);
      end
    end
    burst_resp = 1'b0;
    step();
    chk({tag, "_resp_pulse"}, line_resp, 1'b0);
    chk({tag, "_resp_count"}, resp_seen - r0, 1);
  endtask

  logic [255:0] w1, r2, w3, r4, r5, w6, r6;
  logic [31:0]  a_hold;
  int           r0;

  initial begin
    n_assert = 0; n_fail = 0; resp_seen = 0;
    rst_n = 1'b0; line_read = 1'b0; line_write = 1'b0; line_addr = '0;
    line_wdata = '0; burst_rdata = '0; burst_resp = 1'b0;

    w1 = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303, 64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    r2 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    w3 = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    r4 = {{16{4'h8}}, {16{4'h7}}, {16{4'h6}}, {16{4'h5}}};
    r5 = {64'hF00D_0000_0000_0004, 64'hF00D_0000_0000_0003, 64'hF00D_0000_0000_0002, 64'hF00D_0000_0000_0001};
    w6 = {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003, 64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001};
    r6 = {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003, 64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};

    // Reset state
    step(); step();
    chk("rst_read", burst_read, 1'b0);
    chk("rst_write", burst_write, 1'b0);
    chk("rst_resp", line_resp, 1'b0);
    chk("rst_addr", burst_addr, 32'h0);
    chk("rst_wdata", burst_wdata, 64'h0);
    chk("rst_rdata", line_rdata, 256'h0);
    rst_n = 1'b1;
    step();

    // 1: reset asserted during write beat 2
    line_write = 1'b1; line_addr = 32'h0000_0100; line_wdata = w1; burst_resp = 1'b1;
    step();
    chk("t1_wr_strobe", burst_write, 1'b1);
    chk("t1_beat0", burst_wdata, w1[63:0]);
    line_write = 1'b0;
    step();
    chk("t1_beat1", burst_wdata, w1[127:64]);
    step();
    chk("t1_beat2", burst_wdata, w1[191:128]);
    r0 = resp_seen;
    rst_n = 1'b0;
    #1;
    chk("t1_abort_write", burst_write, 1'b0);
    chk("t1_abort_read", burst_read, 1'b0);
    chk("t1_abort_wdata", burst_wdata, 64'h0);
    chk("t1_abort_resp", line_resp, 1'b0);
    step(); step();
    chk("t1_no_resp", resp_seen - r0, 0);
    burst_resp = 1'b0;
    rst_n = 1'b1;
    step();

    // 2: zero-wait read after the aborted write
    zw_read("t2", 32'h0000_1234, 32'h0000_1220, r2, 1'b0);

    // 3: write beat ordering, line_rdata untouched by writes
    r0 = resp_seen;
    line_write = 1'b1; line_addr = 32'h8000_0040; line_wdata = w3; burst_resp = 1'b1;
    step();
    chk("t3_addr", burst_addr, 32'h8000_0040);
    line_write = 1'b0; line_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_wr_strobe", burst_write, 1'b1);
      chk("t3_wdata", burst_wdata, w3[i*64 +: 64]);
      step();
    end
    chk("t3_wr_drop", burst_write, 1'b0);
    chk("t3_resp", line_resp, 1'b1);
    chk("t3_rdata_kept", line_rdata, r2);
    burst_resp = 1'b0;
    step();
    chk("t3_resp_count", resp_seen - r0, 1);

    // 4: read with 3-cycle gaps between beats
    r0 = resp_seen;
    line_read = 1'b1; line_addr = 32'h0000_0FFF;
    step();
    line_read = 1'b0; line_addr = 32'h0;
    a_hold = 32'h0000_0FE0;
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b0; burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      for (int g = 0; g < 3; g++) begin
        step();
        chk("t4_gap_read", burst_read, 1'b1);
        chk("t4_gap_addr", burst_addr, a_hold);
        chk("t4_gap_resp", line_resp, 1'b0);
      end
      burst_resp = 1'b1; burst_rdata = r4[i*64 +: 64];
      step();
    end
    burst_resp = 1'b0;
    chk("t4_resp", line_resp, 1'b1);
    chk("t4_rdata", line_rdata, r4);
    step();
    chk("t4_resp_count", resp_seen - r0, 1);

    // 5: both requests high -> read only
    zw_read("t5", 32'h1234_5678, 32'h1234_5660, r5, 1'b1);

    // 6: write then read back-to-back, each request held through DONE
    r0 = resp_seen;
    line_write = 1'b1; line_addr = 32'h0000_2000; line_wdata = w6; burst_resp = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t6_wdata", burst_wdata, w6[i*64 +: 64]);
      step();
    end
    chk("t6_wr_resp", line_resp, 1'b1);
    step();
    chk("t6_done_exit_write", burst_write, 1'b0);
    chk("t6_done_exit_read", burst_read, 1'b0);
    chk("t6_wr_count", resp_seen - r0, 1);
    line_write = 1'b0; line_read = 1'b1; line_addr = 32'h0000_3010;
    step();
    chk("t6_rd_accept", burst_read, 1'b1);
    chk("t6_rd_addr", burst_addr, 32'h0000_3000);
    chk("t6_no_write", burst_write, 1'b0);
    for (int i = 0; i < 4; i++) begin
      burst_rdata = r6[i*64 +: 64];
      step();
    end
    chk("t6_rd_resp", line_resp, 1'b1);
    chk("t6_rdata", line_rdata, r6);
    step();
    line_read = 1'b0; burst_resp = 1'b0;
    step();
    chk("t6_no_third", burst_read, 1'b0);
    chk("t6_total_count", resp_seen - r0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
